// File: rtl/bw_digit_downsampler.sv
// Crops a centred ROI from a 1-bit raster stream, thresholds each CELLxCELL cell
// into one bit, and packs the GRIDxGRID bitmap MSB-first into 16-bit words.
module bw_digit_downsampler #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ROI_X0 = 48,
    parameter int ROI_Y0 = 8,
    parameter int CELL   = 8,
    parameter int GRID   = 28,
    parameter int THRESH = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFRAME_START,
    input  logic        iDATA,
    input  logic        iDVAL,
    output logic [15:0] oDATA,
    output logic [5:0]  oADDR,
    output logic        oWE,
    output logic        oFRAME_DONE,
    output logic        oFRAME_ERR,
    output logic        oBUSY
);

    localparam int ROI_W  = GRID * CELL;
    localparam int NWORDS = GRID * GRID / 16;
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H + 1);
    localparam int PW     = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int GW     = $clog2(GRID + 1);
    localparam int CNT_W  = $clog2(CELL * CELL + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [PW-1:0]     px_q, px_d;
    logic [PW-1:0]     py_q, py_d;
    logic [GW-1:0]     cx_q, cx_d;
    logic [GW-1:0]     ry_q, ry_d;
    logic [GRID-1:0]   ser_q, ser_d;
    logic [GW-1:0]     ser_cnt_q, ser_cnt_d;
    logic [14:0]       pack_q, pack_d;
    logic [3:0]        pack_cnt_q, pack_cnt_d;
    logic [5:0]        word_idx_q, word_idx_d;
    logic [15:0]       data_q, data_d;
    logic [5:0]        addr_q, addr_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              roi_x;
    logic              roi_y;
    logic              run_pix;
    logic              pix_hit;
    logic              do_snap;
    logic [GRID-1:0]   snap_bits;

    assign roi_x   = (int'(x_q) >= ROI_X0) && (int'(x_q) < ROI_X0 + ROI_W);
    assign roi_y   = (int'(y_q) >= ROI_Y0) && (int'(y_q) < ROI_Y0 + ROI_W);
    assign run_pix = (state_q == S_RUN) && iDVAL && !iFRAME_START && (int'(y_q) < IMG_H);
    assign pix_hit = run_pix && roi_x && roi_y;
    assign do_snap = pix_hit && (int'(py_q) == CELL - 1) && (int'(x_q) == ROI_X0 + ROI_W - 1);

    // One foreground counter per cell column; the snapshot includes the current pixel.
    generate
        for (genvar gi = 0; gi < GRID; gi++) begin : g_cell
            logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

            always_comb begin
                cnt_inc = cnt_q;
                if (pix_hit && iDATA && (cx_q == GW'(gi))) begin
                    cnt_inc = cnt_q + 1'b1;
                end
                cnt_d = (iFRAME_START || do_snap) ? '0 : cnt_inc;
            end

            assign snap_bits[gi] = (int'(cnt_inc) >= THRESH);

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        px_d       = px_q;
        py_d       = py_q;
        cx_d       = cx_q;
        ry_d       = ry_q;
        ser_d      = ser_q;
        ser_cnt_d  = ser_cnt_q;
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        word_idx_d = word_idx_q;
        data_d     = data_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = 1'b0;

        if (iFRAME_START) begin
            // Acceptance from any state; an active frame is aborted, a finishing one completes.
            state_d    = S_RUN;
            x_d        = '0;
            y_d        = '0;
            px_d       = '0;
            py_d       = '0;
            cx_d       = '0;
            ry_d       = '0;
            ser_d      = '0;
            ser_cnt_d  = '0;
            pack_d     = '0;
            pack_cnt_d = '0;
            word_idx_d = '0;
            err_d      = (state_q == S_RUN) || (state_q == S_FLUSH);
            done_d     = (state_q == S_DONE);
            busy_d     = (state_q != S_DONE);
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_d = 1'b0;
                end
                S_RUN, S_FLUSH: begin
                    busy_d = 1'b1;
                    if (run_pix) begin
                        if (int'(x_q) == IMG_W - 1) begin
                            x_d  = '0;
                            y_d  = y_q + 1'b1;
                            px_d = '0;
                            cx_d = '0;
                            if (roi_y) begin
                                if (int'(py_q) == CELL - 1) begin
                                    py_d = '0;
                                    ry_d = ry_q + 1'b1;
                                end else begin
                                    py_d = py_q + 1'b1;
                                end
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                            if (roi_x) begin
                                if (int'(px_q) == CELL - 1) begin
                                    px_d = '0;
                                    cx_d = cx_q + 1'b1;
                                end else begin
                                    px_d = px_q + 1'b1;
                                end
                            end
                        end
                    end

                    // Serializer drains one bit per cycle; the 16th bit completes a word.
                    if (ser_cnt_q != '0) begin
                        ser_d     = ser_q >> 1;
                        ser_cnt_d = ser_cnt_q - 1'b1;
                        if (pack_cnt_q == 4'd15) begin
                            we_d       = 1'b1;
                            data_d     = {pack_q, ser_q[0]};
                            addr_d     = word_idx_q;
                            word_idx_d = word_idx_q + 1'b1;
                            pack_d     = '0;
                            pack_cnt_d = '0;
                            if (int'(word_idx_q) == NWORDS - 1) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            pack_d     = {pack_q[13:0], ser_q[0]};
                            pack_cnt_d = pack_cnt_q + 1'b1;
                        end
                    end

                    if (do_snap) begin
                        ser_d     = snap_bits;
                        ser_cnt_d = GW'(GRID);
                        if (int'(ry_q) == GRID - 1) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            cx_q       <= '0;
            ry_q       <= '0;
            ser_q      <= '0;
            ser_cnt_q  <= '0;
            pack_q     <= '0;
            pack_cnt_q <= '0;
            word_idx_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cx_q       <= cx_d;
            ry_q       <= ry_d;
            ser_q      <= ser_d;
            ser_cnt_q  <= ser_cnt_d;
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            word_idx_q <= word_idx_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign oDATA       = data_q;
    assign oADDR       = addr_q;
    assign oWE         = we_q;
    assign oFRAME_DONE = done_q;
    assign oFRAME_ERR  = err_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_bw_digit_downsampler.sv
// Directed bench for bw_digit_downsampler on a reduced frame (64x60, 2x2 cells, 28x28 grid)
// so that each full frame is a few thousand cycles.
module tb_bw_digit_downsampler;

    localparam int TW  = 64;
    localparam int TH  = 60;
    localparam int TX0 = 4;
    localparam int TY0 = 2;
    localparam int TC  = 2;
    localparam int TG  = 28;
    localparam int TT  = 2;

    logic        clk = 1'b0;
    logic        iRST;
    logic        iFRAME_START;
    logic        iDATA;
    logic        iDVAL;
    logic [15:0] oDATA;
    logic [5:0]  oADDR;
    logic        oWE;
    logic        oFRAME_DONE;
    logic        oFRAME_ERR;
    logic        oBUSY;

    always #5 clk = ~clk;

    bw_digit_downsampler #(
        .IMG_W(TW), .IMG_H(TH), .ROI_X0(TX0), .ROI_Y0(TY0),
        .CELL(TC), .GRID(TG), .THRESH(TT)
    ) dut (
        .iCLK(clk), .iRST(iRST), .iFRAME_START(iFRAME_START), .iDATA(iDATA), .iDVAL(iDVAL),
        .oDATA(oDATA), .oADDR(oADDR), .oWE(oWE), .oFRAME_DONE(oFRAME_DONE),
        .oFRAME_ERR(oFRAME_ERR), .oBUSY(oBUSY)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture of the write port, restarted by every frame start or reset.
    logic [15:0] word_mem [0:48];
    int   frame_we = 0, order_bad = 0, we_total = 0, done_total = 0, err_total = 0;
    int   done_cyc = 0, last48_cyc = 0, busy_fall_cyc = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        prev_busy <= oBUSY;
        if (prev_busy && !oBUSY) busy_fall_cyc <= cyc;
        if (oFRAME_DONE) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
        if (oFRAME_ERR) err_total <= err_total + 1;
        if (oWE) we_total <= we_total + 1;
        if (iRST || iFRAME_START) begin
            frame_we  <= 0;
            order_bad <= 0;
            for (int i = 0; i < 49; i++) word_mem[i] <= 16'hDEAD;
        end else if (oWE) begin
            if (int'(oADDR) != frame_we) order_bad <= order_bad + 1;
            if (oADDR < 6'd49) word_mem[oADDR] <= oDATA;
            frame_we <= frame_we + 1;
            if (oADDR == 6'd48) last48_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        iFRAME_START = 1'b1;
        iDVAL        = 1'b0;
        tick();
        iFRAME_START = 1'b0;
    endtask

    function automatic logic pix_val(input int mode, input int x, input int y,
                                     input int tr, input int tc, input int n);
        logic in_roi;
        int   cx, cy, li;
        in_roi = (x >= TX0) && (x < TX0 + TG * TC) && (y >= TY0) && (y < TY0 + TG * TC);
        cx = (x - TX0) / TC;
        cy = (y - TY0) / TC;
        li = ((y - TY0) % TC) * TC + (x - TX0) % TC;
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return in_roi && (cx == tc) && (cy == tr) && (li < n);
            default: return !in_roi;
        endcase
    endfunction

    task automatic drive_lines(input int mode, input int tr, input int tc, input int n,
                               input bit gaps, input int stop_y);
        for (int y = 0; y < TH && y != stop_y; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (gaps && $urandom_range(0, 7) == 0) begin
                    iDVAL = 1'b0;
                    iDATA = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 3)) tick();
                end
                iDVAL = 1'b1;
                iDATA = pix_val(mode, x, y, tr, tc, n);
                tick();
            end
        end
        iDVAL = 1'b0;
        iDATA = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [15:0] base_val, input int sp_idx,
                               input logic [15:0] sp_val, input int done_base,
                               input int err_base, input int err_exp);
        int waited = 0;
        while (done_total == done_base && waited < 200) begin
            tick();
            waited++;
        end
        repeat (2) tick();
        n_checks++;
        if (done_total - done_base !== 1)
            $display("FAIL %s done_count: got %0d expected 1", name, done_total - done_base);
        else n_pass++;
        n_checks++;
        if (done_cyc !== last48_cyc + 1)
            $display("FAIL %s done_timing: done at %0d, word48 at %0d", name, done_cyc, last48_cyc);
        else n_pass++;
        n_checks++;
        if (frame_we !== 49)
            $display("FAIL %s word_count: got %0d expected 49", name, frame_we);
        else n_pass++;
        n_checks++;
        if (order_bad !== 0)
            $display("FAIL %s addr_order: %0d out-of-order addresses, expected 0", name, order_bad);
        else n_pass++;
        n_checks++;
        if (err_total - err_base !== err_exp)
            $display("FAIL %s err_count: got %0d expected %0d", name, err_total - err_base, err_exp);
        else n_pass++;
        for (int i = 0; i < 49; i++) begin
            n_checks++;
            if (word_mem[i] !== ((i == sp_idx) ? sp_val : base_val))
                $display("FAIL %s word[%0d]: got %h expected %h", name, i, word_mem[i],
                         (i == sp_idx) ? sp_val : base_val);
            else n_pass++;
        end
        $display("frame %s: %0d words captured, done=%0d err=%0d", name, frame_we,
                 done_total - done_base, err_total - err_base);
    endtask

    task automatic run_frame(input string name, input int mode, input int tr, input int tc,
                             input int n, input bit gaps, input logic [15:0] base_val,
                             input int sp_idx, input logic [15:0] sp_val);
        int db = done_total;
        int eb = err_total;
        start_pulse();
        drive_lines(mode, tr, tc, n, gaps, -1);
        check_frame(name, base_val, sp_idx, sp_val, db, eb, 0);
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (oWE !== 1'b0) $display("FAIL %s oWE: got %b expected 0", name, oWE); else n_pass++;
        n_checks++;
        if (oDATA !== 16'h0) $display("FAIL %s oDATA: got %h expected 0000", name, oDATA); else n_pass++;
        n_checks++;
        if (oADDR !== 6'h0) $display("FAIL %s oADDR: got %0d expected 0", name, oADDR); else n_pass++;
        n_checks++;
        if (oFRAME_DONE !== 1'b0) $display("FAIL %s oFRAME_DONE: got %b expected 0", name, oFRAME_DONE); else n_pass++;
        n_checks++;
        if (oFRAME_ERR !== 1'b0) $display("FAIL %s oFRAME_ERR: got %b expected 0", name, oFRAME_ERR); else n_pass++;
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL %s oBUSY: got %b expected 0", name, oBUSY); else n_pass++;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        iFRAME_START = 1'b0;
        iDATA = 1'b0;
        iDVAL = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("reset");
        tick();
        iRST = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_idle_ignores_data();
        int wb = we_total;
        for (int i = 0; i < 200; i++) begin
            iDVAL = 1'b1;
            iDATA = 1'b1;
            tick();
        end
        iDVAL = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (we_total !== wb) $display("FAIL idle_we: got %0d writes expected 0", we_total - wb); else n_pass++;
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL idle_busy: got %b expected 0", oBUSY); else n_pass++;
        $display("idle: 200 pixels without frame start");
    endtask

    task automatic test_all_ones();
        int db = done_total;
        int eb = err_total;
        start_pulse();
        @(negedge clk);
        n_checks++;
        if (oBUSY !== 1'b1) $display("FAIL ones_busy_start: got %b expected 1", oBUSY); else n_pass++;
        tick();
        drive_lines(1, 0, 0, 0, 1'b0, -1);
        check_frame("all_ones", 16'hFFFF, -1, 16'h0, db, eb, 0);
        n_checks++;
        if (busy_fall_cyc !== done_cyc)
            $display("FAIL ones_busy_fall: fell at %0d, done at %0d", busy_fall_cyc, done_cyc);
        else n_pass++;
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL ones_busy_end: got %b expected 0", oBUSY); else n_pass++;
    endtask

    task automatic test_abort();
        int db = done_total;
        int eb = err_total;
        start_pulse();
        drive_lines(1, 0, 0, 0, 1'b0, 30);
        iFRAME_START = 1'b1;
        @(negedge clk);
        n_checks++;
        if (oFRAME_ERR !== 1'b0) $display("FAIL abort_err_early: got %b expected 0", oFRAME_ERR); else n_pass++;
        tick();
        iFRAME_START = 1'b0;
        @(negedge clk);
        n_checks++;
        if (oFRAME_ERR !== 1'b1) $display("FAIL abort_err_pulse: got %b expected 1", oFRAME_ERR); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (oFRAME_ERR !== 1'b0) $display("FAIL abort_err_width: got %b expected 0", oFRAME_ERR); else n_pass++;
        tick();
        drive_lines(1, 0, 0, 0, 1'b0, -1);
        check_frame("abort_then_ones", 16'hFFFF, -1, 16'h0, db, eb, 1);
    endtask

    task automatic test_reset_mid();
        int wb, db;
        start_pulse();
        drive_lines(1, 0, 0, 0, 1'b0, 20);
        iRST  = 1'b1;
        iDVAL = 1'b1;
        iDATA = 1'b1;
        tick();
        @(negedge clk);
        check_outputs_zero("reset_mid");
        tick();
        iRST = 1'b0;
        wb = we_total;
        db = done_total;
        for (int i = 0; i < 400; i++) begin
            iDVAL = 1'b1;
            iDATA = 1'b1;
            tick();
        end
        iDVAL = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (we_total !== wb) $display("FAIL reset_mid_we: got %0d writes expected 0", we_total - wb); else n_pass++;
        n_checks++;
        if (done_total !== db) $display("FAIL reset_mid_done: got %0d expected 0", done_total - db); else n_pass++;
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", oBUSY); else n_pass++;
        $display("reset_mid: no writes after reset");
    endtask

    initial begin
        iRST = 1'b1;
        iFRAME_START = 1'b0;
        iDATA = 1'b0;
        iDVAL = 1'b0;
        test_reset();
        test_idle_ignores_data();
        run_frame("all_zero", 0, 0, 0, 0, 1'b0, 16'h0000, -1, 16'h0000);
        test_all_ones();
        run_frame("cell00_at_thresh", 2, 0, 0, TT, 1'b0, 16'h0000, 0, 16'h8000);
        run_frame("cell00_below_thresh", 2, 0, 0, TT - 1, 1'b0, 16'h0000, -1, 16'h0000);
        run_frame("cell27_27_full", 2, 27, 27, TC * TC, 1'b0, 16'h0000, 48, 16'h0001);
        run_frame("cell0_16_full", 2, 0, 16, TC * TC, 1'b0, 16'h0000, 1, 16'h8000);
        run_frame("cell1_0_full", 2, 1, 0, TC * TC, 1'b0, 16'h0000, 1, 16'h0008);
        run_frame("outside_roi_gaps", 3, 0, 0, 0, 1'b1, 16'h0000, -1, 16'h0000);
        test_abort();
        test_reset_mid();
        run_frame("recovery_zero", 0, 0, 0, 0, 1'b0, 16'h0000, -1, 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
